// File: rtl/sme_host.sv
// sme_host: host-side initiator for the string-matching engine.
// Buffers one string (<=32 chars) and one pattern (<=8 chars), serializes
// them onto the engine character bus on start, then collects the result.
module sme_host #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_we,
  input  logic       ld_sel,
  input  logic [4:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       start,
  input  logic       send_str,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout
);

  localparam int unsigned STR_DEPTH = 32;
  localparam int unsigned PAT_DEPTH = 8;
  localparam int unsigned CW        = 8;
  localparam int unsigned IW        = 5;
  localparam int unsigned SLW       = 6;
  localparam int unsigned PLW       = 4;
  localparam int unsigned WCW       = 6;

  typedef enum logic [2:0] {
    IDLE,
    SEND_STR,
    SEND_PAT,
    WAIT,
    DONE
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  str_buf [STR_DEPTH];
  logic [CW-1:0]  pat_buf [PAT_DEPTH];
  logic [IW-1:0]  idx, idx_n;
  logic [SLW-1:0] slen, slen_n;
  logic [PLW-1:0] plen, plen_n;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [SLW-1:0] str_len_eff;
  logic [PLW-1:0] pat_len_eff;
  logic           wr_en;

  logic           busy_n, isstring_n, ispattern_n, done_n;
  logic [CW-1:0]  chardata_n;
  logic           res_match_n, timeout_n;
  logic [IW-1:0]  res_index_n;

  // Out-of-range lengths collapse to the full buffer size
  assign str_len_eff = ((str_len == SLW'(0)) || (str_len > SLW'(STR_DEPTH)))
                       ? SLW'(STR_DEPTH) : str_len;
  assign pat_len_eff = ((pat_len == PLW'(0)) || (pat_len > PLW'(PAT_DEPTH)))
                       ? PLW'(PAT_DEPTH) : pat_len;

  // Loads only while idle; a write coinciding with an accepted start is dropped
  assign wr_en = ld_we && (state == IDLE) && !start;

  // Character buffers with space/dot reset fill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STR_DEPTH); i++) str_buf[i] <= 8'h20;
      for (int i = 0; i < int'(PAT_DEPTH); i++) pat_buf[i] <= 8'h2E;
    end else if (wr_en) begin
      if (ld_sel) pat_buf[ld_addr[2:0]] <= ld_data;
      else        str_buf[ld_addr]      <= ld_data;
    end
  end

  // Next state, counters and next-cycle output values
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    slen_n      = slen;
    plen_n      = plen;
    wcnt_n      = wcnt;
    res_match_n = res_match;
    res_index_n = res_index;
    timeout_n   = timeout;

    case (state)
      IDLE: begin
        if (start) begin
          slen_n  = str_len_eff;
          plen_n  = pat_len_eff;
          idx_n   = '0;
          state_n = send_str ? SEND_STR : SEND_PAT;
        end
      end
      SEND_STR: begin
        if (idx == IW'(slen - SLW'(1))) begin
          idx_n   = '0;
          state_n = SEND_PAT;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      SEND_PAT: begin
        if (idx == IW'(plen - PLW'(1))) begin
          idx_n   = '0;
          wcnt_n  = '0;
          state_n = WAIT;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      WAIT: begin
        if (valid) begin
          res_match_n = match;
          res_index_n = match_index;
          timeout_n   = 1'b0;
          state_n     = DONE;
        end else if (wcnt == WCW'(TIMEOUT - 1)) begin
          res_match_n = 1'b0;
          res_index_n = '0;
          timeout_n   = 1'b1;
          state_n     = DONE;
        end else begin
          wcnt_n = wcnt + WCW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n      = (state_n != IDLE);
    isstring_n  = (state_n == SEND_STR);
    ispattern_n = (state_n == SEND_PAT);
    done_n      = (state_n == DONE);
    chardata_n  = '0;
    if (state_n == SEND_STR)      chardata_n = str_buf[idx_n];
    else if (state_n == SEND_PAT) chardata_n = pat_buf[idx_n[2:0]];
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      slen      <= '0;
      plen      <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      chardata  <= '0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      done      <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      slen      <= slen_n;
      plen      <= plen_n;
      wcnt      <= wcnt_n;
      busy      <= busy_n;
      chardata  <= chardata_n;
      isstring  <= isstring_n;
      ispattern <= ispattern_n;
      done      <= done_n;
      res_match <= res_match_n;
      res_index <= res_index_n;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_sme_host.sv
// Bench for sme_host: table-driven transactions, hand-written reset
// sequence and randomized transactions against a buffer/stream model.
module tb_sme_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_we, ld_sel;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       start, send_str;
  logic       busy;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       valid, match;
  logic [4:0] match_index;
  logic       done, res_match, timeout;
  logic [4:0] res_index;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_str [32];
  logic [7:0] m_pat [8];

  typedef struct {
    string      s;
    string      p;
    bit         ss;
    int         sl;
    int         pl;
    bit         respond;
    int         dly;
    bit         m;
    logic [4:0] mi;
    bit         inj_junk;
    bit         inj_valid;
    bit         exp_m;
    logic [4:0] exp_i;
    bit         exp_to;
  } vec_t;

  vec_t tbl [5];

  sme_host #(.TIMEOUT(40)) dut (
    .clk(clk), .reset(reset),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .str_len(str_len), .pat_len(pat_len),
    .start(start), .send_str(send_str),
    .busy(busy), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index),
    .done(done), .res_match(res_match), .res_index(res_index), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_str[i] = 8'h20;
    for (int i = 0; i < 8; i++)  m_pat[i] = 8'h2E;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_strb"},  32'({isstring, ispattern, chardata}), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_res"},   32'({res_match, res_index, timeout}), 0);
  endtask

  task automatic load_buf(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_sel = sel; ld_addr = 5'(i); ld_data = 8'(s[i]);
      if (sel) m_pat[3'(i)] = 8'(s[i]);
      else     m_str[5'(i)] = 8'(s[i]);
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  function automatic vec_t mk(input string s, input string p, input bit ss, input int sl,
                              input int pl, input bit respond, input int dly, input bit m,
                              input logic [4:0] mi, input bit inj_junk, input bit inj_valid,
                              input bit exp_m, input logic [4:0] exp_i, input bit exp_to);
    vec_t v;
    v.s = s; v.p = p; v.ss = ss; v.sl = sl; v.pl = pl; v.respond = respond; v.dly = dly;
    v.m = m; v.mi = mi; v.inj_junk = inj_junk; v.inj_valid = inj_valid;
    v.exp_m = exp_m; v.exp_i = exp_i; v.exp_to = exp_to;
    return v;
  endfunction

  // One full transaction: expected stream comes from the buffer model
  task automatic run_txn(input bit ss, input int sl, input int pl, input bit respond,
                         input int dly, input bit m, input logic [4:0] mi,
                         input bit inj_junk, input bit inj_valid, input bit same_we,
                         input bit exp_m, input logic [4:0] exp_i, input bit exp_to);
    int         L, P, n, wc;
    bit         exp_isstr [$];
    logic [7:0] exp_ch [$];
    L = (sl == 0 || sl > 32) ? 32 : sl;
    P = (pl == 0 || pl > 8) ? 8 : pl;
    if (ss) for (int k = 0; k < L; k++) begin exp_isstr.push_back(1'b1); exp_ch.push_back(m_str[k]); end
    for (int j = 0; j < P; j++) begin exp_isstr.push_back(1'b0); exp_ch.push_back(m_pat[j]); end
    n = exp_isstr.size();

    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    start = 1'b1; send_str = ss; str_len = 6'(sl); pat_len = 4'(pl);
    if (same_we) begin ld_we = 1'b1; ld_sel = 1'b0; ld_addr = 5'd0; ld_data = 8'h7E; end

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0; ld_we = 1'b0; valid = 1'b0; match = 1'b0;
      check("stream_busy", 32'(busy), 1);
      check("isstring",    32'(isstring), 32'(exp_isstr[k]));
      check("ispattern",   32'(ispattern), 32'(!exp_isstr[k]));
      check("chardata",    32'(chardata), 32'(exp_ch[k]));
      if (inj_junk && k == 1) begin
        start = 1'b1; send_str = 1'b1;
        ld_we = 1'b1; ld_sel = 1'b0; ld_addr = 5'd4; ld_data = 8'h5A;
      end
      if (inj_valid && k == n - P) begin
        valid = 1'b1; match = 1'b1; match_index = 5'd31;
      end
    end

    @(negedge clk);
    start = 1'b0; ld_we = 1'b0; valid = 1'b0; match = 1'b0;
    check("wait_strobes", 32'({isstring, ispattern, chardata}), 0);
    check("wait_busy", 32'(busy), 1);

    if (respond) begin
      for (int d = 0; d < dly; d++) @(negedge clk);
      check("pre_valid_done", 32'(done), 0);
      valid = 1'b1; match = m; match_index = mi;
      @(negedge clk);
      valid = 1'b0; match = 1'b0; match_index = 5'd0;
      check("done_pulse", 32'(done), 1);
      check("done_busy",  32'(busy), 1);
    end else begin
      wc = 0;
      while (done !== 1'b1 && wc < 100) begin
        @(negedge clk);
        wc++;
      end
      check("timeout_cycles", 32'(wc), 40);
    end
    check("res_match", 32'(res_match), 32'(exp_m));
    check("res_index", 32'(res_index), 32'(exp_i));
    check("timeout",   32'(timeout), 32'(exp_to));
    @(negedge clk);
    check("after_busy", 32'(busy), 0);
    check("after_done", 32'(done), 0);
    check("hold_res", 32'({res_match, res_index, timeout}), 32'({exp_m, exp_i, exp_to}));
  endtask

  initial begin
    bit         r_ss, r_resp, r_m, r_we;
    logic [4:0] r_mi;
    logic [4:0] wa;
    logic [7:0] wd;
    bit         ws;

    reset = 1'b1; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    str_len = '0; pat_len = '0; start = 1'b0; send_str = 1'b0;
    valid = 1'b0; match = 1'b0; match_index = '0;
    model_reset();

    tbl[0] = mk("abcde", "cd", 1, 5, 2, 1, 3,  1, 5'd2,  0, 0, 1, 5'd2,  0);
    tbl[1] = mk("",      "^a", 0, 5, 2, 1, 0,  1, 5'd0,  0, 0, 1, 5'd0,  0);
    tbl[2] = mk("",      "",   1, 5, 2, 0, 0,  0, 5'd0,  0, 0, 0, 5'd0,  1);
    tbl[3] = mk("",      "",   1, 8, 2, 1, 1,  0, 5'd7,  1, 0, 0, 5'd7,  0);
    tbl[4] = mk("",      "",   1, 3, 2, 1, 5,  1, 5'd9,  0, 1, 1, 5'd9,  0);

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].s.len() > 0) load_buf(1'b0, tbl[t].s);
      if (tbl[t].p.len() > 0) load_buf(1'b1, tbl[t].p);
      run_txn(tbl[t].ss, tbl[t].sl, tbl[t].pl, tbl[t].respond, tbl[t].dly, tbl[t].m,
              tbl[t].mi, tbl[t].inj_junk, tbl[t].inj_valid, 1'b0,
              tbl[t].exp_m, tbl[t].exp_i, tbl[t].exp_to);
    end

    // Reset asserted in the middle of the pattern burst
    load_buf(1'b0, "abcdef");
    load_buf(1'b1, "xyz");
    @(negedge clk);
    start = 1'b1; send_str = 1'b1; str_len = 6'd6; pat_len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_ispattern", 32'(ispattern), 1);
    check("pre_rst_char", 32'(chardata), 32'h78);
    #2 reset = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Defaults in unloaded slots, out-of-range lengths
    load_buf(1'b0, "hi");
    load_buf(1'b1, "x");
    run_txn(1'b1, 0, 12, 1'b1, 2, 1'b0, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0, 5'd17, 1'b0);

    // Randomized transactions
    for (int r = 0; r < 25; r++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
        ws = 1'($urandom_range(0, 1));
        wa = 5'($urandom_range(0, 31));
        wd = 8'($urandom_range(33, 126));
        @(negedge clk);
        ld_we = 1'b1; ld_sel = ws; ld_addr = wa; ld_data = wd;
        if (ws) m_pat[wa[2:0]] = wd;
        else    m_str[wa] = wd;
      end
      @(negedge clk);
      ld_we = 1'b0;
      r_ss   = 1'($urandom_range(0, 1));
      r_resp = ($urandom_range(0, 4) != 0);
      r_m    = 1'($urandom_range(0, 1));
      r_mi   = 5'($urandom_range(0, 31));
      r_we   = ($urandom_range(0, 3) == 0);
      run_txn(r_ss, int'($urandom_range(0, 40)), int'($urandom_range(0, 15)), r_resp,
              int'($urandom_range(0, 39)), r_m, r_mi, 1'b0, 1'b0, r_we,
              r_resp ? r_m : 1'b0, r_resp ? r_mi : 5'd0, !r_resp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
